// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter
// Shares one 74181-style 4-bit logic unit between NUM_REQ requesters.
// Requests arrive on per-requester valid/ready handshakes; at most one
// operation is in flight, and its result returns on a tagged response channel.
//
// Build option:
//   ALU_LOGIC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                                undefined -> round-robin starting after the last winner
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrating; winner gets req_ready combinationally
// EXEC  | registered operands on the shared unit, result captured at edge
// RESP  | rsp_valid high, result held until rsp_ready

module alu_logic_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0] req_s,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    input  logic [3:0]           alu_f,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [3:0]           rsp_f,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           accept;

    logic [3:0]     sel_a;
    logic [3:0]     sel_b;
    logic [3:0]     sel_s;

    logic [3:0]     op_a;
    logic [3:0]     op_b;
    logic [3:0]     op_s;
    logic [IDW-1:0] cur_id;
    logic [3:0]     rsp_f_q;

`ifdef ALU_LOGIC_ARB_FIXED_PRIO_EN

    // Fixed priority: scan downwards so the lowest valid index is the last write.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end

`else

    logic [IDW-1:0] last_grant;
    logic           hi_found;
    logic [IDW-1:0] hi_id;
    logic [IDW-1:0] lo_id;

    // Round-robin: lowest valid index above last_grant wins, else wrap to lowest valid overall.
    always_comb begin
        win_found = 1'b0;
        hi_found  = 1'b0;
        hi_id     = '0;
        lo_id     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                lo_id     = IDW'(i);
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
    end

    // Remember the winner so it drops to lowest priority next time; reset makes requester 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            last_grant <= win_id;
        end
    end

`endif

    assign accept = (state == IDLE) && win_found;

    // Select the winning requester's operand fields.
    always_comb begin
        sel_a = 4'h0;
        sel_b = 4'h0;
        sel_s = 4'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_a = req_a[4*i +: 4];
                sel_b = req_b[4*i +: 4];
                sel_s = req_s[4*i +: 4];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, owner and result registers; operands only move on an accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= 4'h0;
            op_b    <= 4'h0;
            op_s    <= 4'h0;
            cur_id  <= '0;
            rsp_f_q <= 4'h0;
        end else begin
            if (accept) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_s   <= sel_s;
                cur_id <= win_id;
            end
            if (state == EXEC) begin
                rsp_f_q <= alu_f;
            end
        end
    end

    // FSM outputs; everything handshake-related is forced quiet while rst is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && accept && (win_id == IDW'(i));
        end
        rsp_valid = !rst && (state == RESP);
        busy      = !rst && (state != IDLE);
    end

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_s  = op_s;
    assign rsp_id = cur_id;
    assign rsp_f  = rsp_f_q;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Self-checking bench for alu_logic_arbiter with a behavioural 74181 logic unit
// and a scoreboard of expected responses keyed by accept order.
module tb_alu_logic_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a = '0;
    logic [4*NUM_REQ-1:0] req_b = '0;
    logic [4*NUM_REQ-1:0] req_s = '0;
    logic [3:0]           alu_a;
    logic [3:0]           alu_b;
    logic [3:0]           alu_s;
    logic [3:0]           alu_f;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;
    logic [3:0]           rsp_f;
    logic                 busy;

    int checks = 0;
    int passes = 0;
    int id3_grants = 0;
    int id3_rsps = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [3:0]     f;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] sel_tab [16] = '{4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h5, 4'h6, 4'h4,
                                 4'hB, 4'h9, 4'hA, 4'h8, 4'hF, 4'hD, 4'hE, 4'hC};

    alu_logic_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_f     (alu_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] f181(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return ~a;
            4'd1:    return ~(a | b);
            4'd2:    return ~a & b;
            4'd3:    return 4'h0;
            4'd4:    return ~(a & b);
            4'd5:    return ~b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~a | b;
            4'd9:    return ~(a ^ b);
            4'd10:   return b;
            4'd11:   return a & b;
            4'd12:   return 4'hF;
            4'd13:   return a | ~b;
            4'd14:   return a | b;
            default: return a;
        endcase
    endfunction

    assign alu_f = f181(alu_a, alu_b, alu_s);

    // Scoreboard: push on accept, pop and compare on response handshake; reset drops in-flight work.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (rsp_id == 2'd3) id3_rsps++;
                checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got id=%0d f=%h, required no response", rsp_id, rsp_f);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_id !== e.id || rsp_f !== e.f)
                        $display("FAIL sb_rsp: got id=%0d f=%h, required id=%0d f=%h", rsp_id, rsp_f, e.id, e.f);
                    else
                        passes++;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = 2'(i);
                    e.f  = f181(req_a[4*i +: 4], req_b[4*i +: 4], req_s[4*i +: 4]);
                    sb_q.push_back(e);
                    if (i == 3) id3_grants++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        req_valid[i]     = v;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_s[4*i +: 4]  = s;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        cyc();
        cyc();
        settle();
        checks++;
        if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b, required 0000", req_ready);
        else passes++;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_flags: got rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        else passes++;
        checks++;
        if ({alu_a, alu_b, alu_s} !== 12'h000) $display("FAIL rst_operands: got %h, required 000", {alu_a, alu_b, alu_s});
        else passes++;
        checks++;
        if (rsp_f !== 4'h0 || rsp_id !== 2'd0) $display("FAIL rst_rsp: got f=%h id=%0d, required 0 0", rsp_f, rsp_id);
        else passes++;
        req_valid = '0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_op();
        set_req(2, 1'b1, 4'h5, 4'h3, 4'd6);
        settle();
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b, required 0100", req_ready);
        else passes++;
        cyc();
        set_req(2, 1'b0, 4'h0, 4'h0, 4'h0);
        settle();
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL single_exec: got busy=%b rsp_valid=%b, required 1 0", busy, rsp_valid);
        else passes++;
        checks++;
        if ({alu_a, alu_b, alu_s} !== 12'h536) $display("FAIL single_alu_drive: got %h, required 536", {alu_a, alu_b, alu_s});
        else passes++;
        cyc();
        settle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_f !== 4'h6)
            $display("FAIL single_rsp: got v=%b id=%0d f=%h, required 1 2 6", rsp_valid, rsp_id, rsp_f);
        else passes++;
        cyc();
        settle();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle: got v=%b busy=%b, required 0 0", rsp_valid, busy);
        else passes++;
    endtask

    task automatic test_fairness();
        int got;
        int last_n;
        int n;
        logic [IDW-1:0] exp_id;
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'hF, 4'(i), 4'd11);
        got = 0;
        last_n = 0;
        n = 0;
        while (got < 5 && n < 100) begin
            settle();
            if (rsp_valid) begin
`ifdef ALU_LOGIC_ARB_FIXED_PRIO_EN
                exp_id = 2'd0;
`else
                exp_id = 2'(got % NUM_REQ);
`endif
                checks++;
                if (rsp_id !== exp_id || rsp_f !== {2'b00, exp_id})
                    $display("FAIL fair_%0d: got id=%0d f=%h, required id=%0d f=%h", got, rsp_id, rsp_f, exp_id, {2'b00, exp_id});
                else passes++;
                if (got > 0) begin
                    checks++;
                    if (n - last_n != 3) $display("FAIL fair_interval_%0d: got %0d cycles, required 3", got, n - last_n);
                    else passes++;
                end
                last_n = n;
                got++;
                if (got == 5) req_valid = '0;
            end
            cyc();
            n++;
        end
        if (got < 5) begin
            checks++;
            $display("FAIL fair_timeout: got %0d responses, required 5", got);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'h9, 4'h6, 4'd14);
        settle();
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL bp_first_ready: got %b, required 0001", req_ready);
        else passes++;
        cyc();
        set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_req(1, 1'b1, 4'h3, 4'h5, 4'd6);
        rsp_ready = 1'b0;
        settle();
        checks++;
        if (req_ready !== 4'b0000) $display("FAIL bp_exec_ready: got %b, required 0000", req_ready);
        else passes++;
        cyc();
        settle();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_f !== 4'hF || req_ready !== 4'b0000)
                $display("FAIL bp_hold_%0d: got v=%b id=%0d f=%h ready=%b, required 1 0 f 0000", k, rsp_valid, rsp_id, rsp_f, req_ready);
            else passes++;
            cyc();
            settle();
        end
        rsp_ready = 1'b1;
        #0;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000)
            $display("FAIL bp_handshake: got v=%b ready=%b, required 1 0000", rsp_valid, req_ready);
        else passes++;
        cyc();
        settle();
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL bp_next_accept: got %b, required 0010", req_ready);
        else passes++;
        cyc();
        set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
        cyc();
        settle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_f !== 4'h6)
            $display("FAIL bp_second_rsp: got v=%b id=%0d f=%h, required 1 1 6", rsp_valid, rsp_id, rsp_f);
        else passes++;
        cyc();
    endtask

    task automatic test_select_coverage();
        int w;
        rsp_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            set_req(0, 1'b1, 4'hC, 4'hA, 4'(s));
            settle();
            w = 0;
            while (!req_ready[0] && w < 10) begin
                cyc();
                settle();
                w++;
            end
            if (!req_ready[0]) begin
                checks++;
                $display("FAIL sel_%0d_accept_timeout: got ready=%b, required bit 0", s, req_ready);
            end
            cyc();
            set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
            settle();
            w = 0;
            while (!rsp_valid && w < 10) begin
                cyc();
                settle();
                w++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_f !== sel_tab[s])
                $display("FAIL sel_%0d: got v=%b f=%h, required 1 %h", s, rsp_valid, rsp_f, sel_tab[s]);
            else passes++;
            cyc();
        end
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 4'h7, 4'h7, 4'd6);
        settle();
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL rmid_accept: got %b, required 0010", req_ready);
        else passes++;
        cyc();
        set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        settle();
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) $display("FAIL rmid_during: got ready=%b v=%b, required 0000 0", req_ready, rsp_valid);
        else passes++;
        cyc();
        rst = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL rmid_idle: got busy=%b v=%b, required 0 0", busy, rsp_valid);
        else passes++;
        checks++;
        if ({alu_a, alu_b, alu_s} !== 12'h000) $display("FAIL rmid_operands: got %h, required 000", {alu_a, alu_b, alu_s});
        else passes++;
        cyc();
        settle();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_no_rsp: got v=%b busy=%b, required 0 0", rsp_valid, busy);
        else passes++;
        set_req(0, 1'b1, 4'h1, 4'h2, 4'd14);
        set_req(2, 1'b1, 4'h4, 4'h4, 4'd14);
        settle();
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL rmid_restart: got %b, required 0001", req_ready);
        else passes++;
        cyc();
        req_valid = '0;
        cyc();
        settle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_f !== 4'h3)
            $display("FAIL rmid_rsp: got v=%b id=%0d f=%h, required 1 0 3", rsp_valid, rsp_id, rsp_f);
        else passes++;
        cyc();
    endtask

    task automatic test_withdraw();
        int g3;
        int r3;
        g3 = id3_grants;
        r3 = id3_rsps;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'hA, 4'h5, 4'd6);
        settle();
        cyc();
        set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
        rsp_ready = 1'b0;
        cyc();
        set_req(3, 1'b1, 4'h1, 4'h1, 4'd15);
        settle();
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) $display("FAIL wd_in_resp: got v=%b ready=%b, required 1 0000", rsp_valid, req_ready);
        else passes++;
        cyc();
        req_valid[3] = 1'b0;
        settle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_f !== 4'hF) $display("FAIL wd_hold: got v=%b f=%h, required 1 f", rsp_valid, rsp_f);
        else passes++;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        settle();
        checks++;
        if (busy !== 1'b0 || id3_grants != g3 || id3_rsps != r3)
            $display("FAIL wd_never_granted: got busy=%b grants3=%0d rsps3=%0d, required 0 %0d %0d", busy, id3_grants, id3_rsps, g3, r3);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_select_coverage();
        test_reset_mid_op();
        test_withdraw();
        cyc();
        cyc();
        checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
